decode: RTL and testbench

- Second pipeline stage of the core. Sits directly downstream of the fetch stage and consumes its instruction stream (I_VALID / I_ADDR / I_DATA).
- Fetch has no backpressure input. Decode therefore buffers instructions in a small queue and raises O_STALL_REQ so the core holds the fetch PC (ORed into the fetch-advance condition alongside MEM_WAIT).
- Decode splits out instruction fields, reads the 32x32 register file (write-through bypass), and presents a registered decoded bundle to execute.

---
 rtl/decode.sv | 195 +++++++++++++++++++
 tb/tb_decode.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// Decode stage: buffers the fetch instruction stream in a small circular
// queue, splits out instruction fields, reads the register file with
// write-through bypass and presents a registered decoded bundle to execute.
module decode #(
  parameter int QDEPTH    = 4,
  parameter int AFULL_LVL = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        I_VALID,
  input  logic [31:0] I_ADDR,
  input  logic [31:0] I_DATA,
  input  logic        FLUSH,
  input  logic        STALL,
  input  logic        W_EN,
  input  logic [4:0]  W_RD,
  input  logic [31:0] W_DATA,
  output logic        O_STALL_REQ,
  output logic        O_OVERFLOW,
  output logic        O_VALID,
  output logic [31:0] O_ADDR,
  output logic [5:0]  O_OPCODE,
  output logic [4:0]  O_RD,
  output logic [31:0] O_RS1_DATA,
  output logic [31:0] O_RS2_DATA,
  output logic [31:0] O_IMM,
  output logic        O_ILLEGAL
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(QDEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LVL);

  logic [31:0]   qa_q [QDEPTH];
  logic [31:0]   qd_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, drop;

  logic [31:0]   rf_q [32];

  logic [31:0]   head_addr, head_data;
  logic [4:0]    rs1_idx, rs2_idx;
  logic [31:0]   rs1_val, rs2_val;

  logic          valid_q, valid_d;
  logic [31:0]   addr_q, addr_d;
  logic [5:0]    opcode_q, opcode_d;
  logic [4:0]    rd_q, rd_d;
  logic [31:0]   rs1_q, rs1_d;
  logic [31:0]   rs2_q, rs2_d;
  logic [31:0]   imm_q, imm_d;
  logic          illegal_q, illegal_d;

  // Queue control: flush wins over push/pop; a pop frees a slot for a same-cycle push.
  always_comb begin
    pop      = !FLUSH && !STALL && (count_q != '0);
    push     = !FLUSH && I_VALID && ((count_q != FULL_CNT) || pop);
    drop     = !FLUSH && I_VALID && (count_q == FULL_CNT) && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | drop;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Queue pointers, occupancy and sticky overflow flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Queue storage written at the tail on push.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < QDEPTH; i++) begin
        qa_q[i] <= '0;
        qd_q[i] <= '0;
      end
    end else if (push) begin
      qa_q[wr_ptr_q] <= I_ADDR;
      qd_q[wr_ptr_q] <= I_DATA;
    end
  end

  // Register file; r0 is never written so it always reads zero.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (W_EN && (W_RD != 5'd0)) begin
      rf_q[W_RD] <= W_DATA;
    end
  end

  // Head-of-queue operand read with same-cycle writeback forwarding.
  always_comb begin
    head_addr = qa_q[rd_ptr_q];
    head_data = qd_q[rd_ptr_q];
    rs1_idx   = head_data[20:16];
    rs2_idx   = head_data[15:11];
    if (rs1_idx == 5'd0)                    rs1_val = '0;
    else if (W_EN && (W_RD == rs1_idx))     rs1_val = W_DATA;
    else                                    rs1_val = rf_q[rs1_idx];
    if (rs2_idx == 5'd0)                    rs2_val = '0;
    else if (W_EN && (W_RD == rs2_idx))     rs2_val = W_DATA;
    else                                    rs2_val = rf_q[rs2_idx];
  end

  // Output bundle next state: hold under STALL, load on pop, drop valid when empty.
  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    opcode_d  = opcode_q;
    rd_d      = rd_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    imm_d     = imm_q;
    illegal_d = illegal_q;
    if (FLUSH) begin
      valid_d = 1'b0;
    end else if (!STALL) begin
      if (pop) begin
        valid_d   = 1'b1;
        addr_d    = head_addr;
        opcode_d  = head_data[31:26];
        rd_d      = head_data[25:21];
        rs1_d     = rs1_val;
        rs2_d     = rs2_val;
        imm_d     = {{16{head_data[15]}}, head_data[15:0]};
        illegal_d = (head_data[31:26] > 6'h05);
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // Output bundle registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      opcode_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      opcode_q  <= opcode_d;
      rd_q      <= rd_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      imm_q     <= imm_d;
      illegal_q <= illegal_d;
    end
  end

  assign O_STALL_REQ = (count_q >= AFULL_CNT);
  assign O_OVERFLOW  = ovf_q;
  assign O_VALID     = valid_q;
  assign O_ADDR      = addr_q;
  assign O_OPCODE    = opcode_q;
  assign O_RD        = rd_q;
  assign O_RS1_DATA  = rs1_q;
  assign O_RS2_DATA  = rs2_q;
  assign O_IMM       = imm_q;
  assign O_ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_decode.sv
// Directed bench for the decode stage.
module tb_decode;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic        flush;
  logic        stall;
  logic        w_en;
  logic [4:0]  w_rd;
  logic [31:0] w_data;
  logic        o_stall_req;
  logic        o_overflow;
  logic        o_valid;
  logic [31:0] o_addr;
  logic [5:0]  o_opcode;
  logic [4:0]  o_rd;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic [31:0] o_imm;
  logic        o_illegal;

  int errors = 0;
  int checks = 0;

  decode #(.QDEPTH(4), .AFULL_LVL(2)) dut (
    .CLK(clk), .RST(rst), .I_VALID(i_valid), .I_ADDR(i_addr), .I_DATA(i_data),
    .FLUSH(flush), .STALL(stall), .W_EN(w_en), .W_RD(w_rd), .W_DATA(w_data),
    .O_STALL_REQ(o_stall_req), .O_OVERFLOW(o_overflow), .O_VALID(o_valid),
    .O_ADDR(o_addr), .O_OPCODE(o_opcode), .O_RD(o_rd), .O_RS1_DATA(o_rs1_data),
    .O_RS2_DATA(o_rs2_data), .O_IMM(o_imm), .O_ILLEGAL(o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [15:0] lo);
    return {op, rd, rs1, lo};
  endfunction

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_data = '0; flush = 1'b0;
    stall = 1'b0; w_en = 1'b0; w_rd = '0; w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", o_valid, 0);
    check("rst_ovf", o_overflow, 0);
    check("rst_illegal", o_illegal, 0);
    check("rst_addr", o_addr, 0);
    check("rst_imm", o_imm, 0);
    check("rst_sreq", o_stall_req, 0);
    rst = 1'b0;

    // Streaming: each bundle appears two edges after its push
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        i_valid = 1'b1; i_addr = 32'(4 * i); i_data = 32'h04221800;
      end else begin
        i_valid = 1'b0;
      end
      step();
      if (i >= 1 && i <= 4) begin
        check("t1_valid", o_valid, 1);
        check("t1_addr", o_addr, 32'(4 * (i - 1)));
        check("t1_opcode", o_opcode, 6'h01);
        check("t1_rd", o_rd, 5'd1);
        check("t1_imm", o_imm, 32'h00001800);
      end
      if (i == 5) check("t1_empty_valid", o_valid, 0);
      check("t1_sreq", o_stall_req, 0);
    end

    // Stall, fill, overflow, drain
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_addr = 32'h100 + 32'(4 * i);
      i_data = mk(6'(2 + i), 5'(i + 1), 5'd0, 16'h8000 | 16'(i));
      step();
      check("t2_sreq", o_stall_req, (i >= 1) ? 1 : 0);
      check("t2_hold_valid", o_valid, 0);
      check("t2_no_ovf", o_overflow, 0);
    end
    i_addr = 32'h110; i_data = mk(6'h00, 5'd9, 5'd0, 16'h0009);
    step();
    i_valid = 1'b0;
    check("t2_ovf", o_overflow, 1);
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_valid", o_valid, 1);
      check("t2_addr", o_addr, 32'h100 + 32'(4 * i));
      check("t2_opcode", o_opcode, 32'(2 + i));
      check("t2_rd", o_rd, 32'(i + 1));
      check("t2_imm", o_imm, 32'hFFFF8000 | 32'(i));
      check("t2_illegal", o_illegal, 0);
    end
    step();
    check("t2_drained", o_valid, 0);
    check("t2_ovf_sticky", o_overflow, 1);

    // Sign extension and illegal opcode
    i_valid = 1'b1; i_addr = 32'h200; i_data = 32'h0000FFFF;
    step();
    i_addr = 32'h204; i_data = 32'hFC000000;
    step();
    i_valid = 1'b0;
    check("t3_addr0", o_addr, 32'h200);
    check("t3_imm_neg", o_imm, 32'hFFFFFFFF);
    check("t3_legal", o_illegal, 0);
    step();
    check("t3_valid", o_valid, 1);
    check("t3_addr1", o_addr, 32'h204);
    check("t3_opcode", o_opcode, 6'h3F);
    check("t3_illegal", o_illegal, 1);
    step();
    check("t3_empty", o_valid, 0);

    // Writeback forwarding at pop
    i_valid = 1'b1; i_addr = 32'h300; i_data = mk(6'h00, 5'd0, 5'd3, 16'h0000);
    step();
    i_valid = 1'b0; w_en = 1'b1; w_rd = 5'd3; w_data = 32'hDEADBEEF;
    step();
    w_en = 1'b0;
    check("t4_bypass_rs1", o_rs1_data, 32'hDEADBEEF);
    i_valid = 1'b1; i_addr = 32'h304; i_data = mk(6'h00, 5'd0, 5'd0, 16'h1800);
    step();
    i_valid = 1'b0;
    step();
    check("t4_stored_rs2", o_rs2_data, 32'hDEADBEEF);
    check("t4_r0_rs1", o_rs1_data, 0);
    // r0 writes are ignored, stored or forwarded
    w_en = 1'b1; w_rd = 5'd0; w_data = 32'h12345678;
    step();
    w_en = 1'b0;
    i_valid = 1'b1; i_addr = 32'h308; i_data = mk(6'h00, 5'd0, 5'd0, 16'h0000);
    step();
    i_valid = 1'b0; w_en = 1'b1; w_rd = 5'd0; w_data = 32'h87654321;
    step();
    w_en = 1'b0;
    check("t4_r0_valid", o_valid, 1);
    check("t4_r0_read", o_rs1_data, 0);
    // A write during a held output does not disturb it
    i_valid = 1'b1; i_addr = 32'h30C; i_data = mk(6'h00, 5'd0, 5'd5, 16'h0000);
    step();
    i_valid = 1'b0;
    step();
    check("t4_pre_stall", o_rs1_data, 0);
    stall = 1'b1; w_en = 1'b1; w_rd = 5'd5; w_data = 32'hCAFE0005;
    step();
    w_en = 1'b0;
    check("t4_held_rs1", o_rs1_data, 0);
    check("t4_held_valid", o_valid, 1);
    check("t4_held_addr", o_addr, 32'h30C);
    stall = 1'b0;
    step();
    check("t4_after_stall", o_valid, 0);
    i_valid = 1'b1; i_addr = 32'h310; i_data = mk(6'h00, 5'd0, 5'd5, 16'h0000);
    step();
    i_valid = 1'b0;
    step();
    check("t4_r5_written", o_rs1_data, 32'hCAFE0005);

    // Asynchronous reset between edges
    i_valid = 1'b1; i_addr = 32'h400; i_data = mk(6'h3F, 5'd7, 5'd3, 16'h1234);
    step();
    i_valid = 1'b0;
    step();
    check("t6_pre_valid", o_valid, 1);
    check("t6_pre_illegal", o_illegal, 1);
    check("t6_pre_rs1", o_rs1_data, 32'hDEADBEEF);
    #3;
    rst = 1'b1;
    #1;
    check("t6_valid", o_valid, 0);
    check("t6_addr", o_addr, 0);
    check("t6_illegal", o_illegal, 0);
    check("t6_ovf", o_overflow, 0);
    check("t6_rs1", o_rs1_data, 0);
    check("t6_imm", o_imm, 0);
    check("t6_opcode", o_opcode, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    i_valid = 1'b1; i_addr = 32'h404; i_data = mk(6'h00, 5'd0, 5'd3, 16'h0000);
    step();
    i_valid = 1'b0;
    step();
    check("t6_rf_cleared", o_rs1_data, 0);
    check("t6_rf_valid", o_valid, 1);

    // Flush with three queued entries
    i_valid = 1'b1; i_addr = 32'h500;
    step();
    i_addr = 32'h504;
    step();
    stall = 1'b1; i_addr = 32'h508;
    step();
    i_addr = 32'h50C;
    step();
    check("t5_pre_valid", o_valid, 1);
    check("t5_pre_addr", o_addr, 32'h500);
    check("t5_pre_sreq", o_stall_req, 1);
    flush = 1'b1; i_addr = 32'h510;
    step();
    flush = 1'b0; i_valid = 1'b0; stall = 1'b0;
    check("t5_valid", o_valid, 0);
    check("t5_sreq", o_stall_req, 0);
    check("t5_ovf", o_overflow, 0);
    step();
    check("t5_empty", o_valid, 0);
    i_valid = 1'b1; i_addr = 32'h520;
    step();
    i_valid = 1'b0;
    check("t5_no_bypass", o_valid, 0);
    step();
    check("t5_late_valid", o_valid, 1);
    check("t5_late_addr", o_addr, 32'h520);
    step();
    check("t5_late_empty", o_valid, 0);

    // Flush on a full queue drops I_VALID without flagging overflow
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_addr = 32'h600 + 32'(4 * i);
      step();
    end
    flush = 1'b1; i_addr = 32'h610;
    step();
    flush = 1'b0; i_valid = 1'b0;
    check("t5_full_ovf", o_overflow, 0);
    check("t5_full_sreq", o_stall_req, 0);
    stall = 1'b0;
    step();
    check("t5_full_empty", o_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
